parity_frame_serializer: RTL and testbench

//  Accepts 7-bit data words over a valid/ready handshake and builds the 8-bit codeword
//  {d[6:4], m, d[3:0]}, where m is the majority-marker bit. Shifts the codeword out one
//  bit per clock with framing strobes. Sits between the word source and the serial link.

---
 rtl/parity_ser_pkg.sv | 19 +
 rtl/marker_codeword_gen.sv | 28 ++
 rtl/parity_frame_serializer.sv | 137 +++++++++++++
 tb/tb_parity_frame_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_ser_pkg.sv
// Shared types and constants for the parity frame serializer.
// Codeword layout is {d[6:4], m, d[3:0]} with the marker at MARK_POS.
package parity_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int CODE_W   = 8;
    localparam int DATA_W   = 7;
    localparam int MARK_POS = 4;
    localparam int BIT_CNT_W = $clog2(CODE_W);

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_ONE  = 1'b1;

endpackage

// File: rtl/marker_codeword_gen.sv
// Combinational codeword builder: inserts the majority-marker bit into a data word.
// d[6] is deliberately left out of the ones count.
module marker_codeword_gen
    import parity_ser_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic              mode,
    output logic [CODE_W-1:0] codeword
);

    logic [2:0] n1;
    logic       m;

    always_comb begin
        n1 = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n1 = n1 + {2'b00, d[i]};
        end
        // A 3/3 split fails both tests, so the tie always yields m = 0.
        if (mode == MODE_ONE) begin
            m = (n1 >= 3'd4);
        end else begin
            m = (n1 <= 3'd2);
        end
        codeword = {d[DATA_W-1:MARK_POS], m, d[MARK_POS-1:0]};
    end

endmodule

// File: rtl/parity_frame_serializer.sv
// Accepts 7-bit words, builds marker codewords and shifts them out one bit per clock
// with frame strobes, an optional inter-frame gap and a wrapping frame counter.
module parity_frame_serializer
    import parity_ser_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count
);

    localparam bit                 BACK_TO_BACK = (GAP_CYCLES == 0);
    localparam logic [3:0]         GAP_LOAD     = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(CODE_W - 1);

    state_t                 state_q, state_d;
    logic [CODE_W-1:0]      shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ser_out_q, ser_out_d;
    logic                   ser_valid_q, ser_valid_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic [CODE_W-1:0]      codeword;
    logic                   accept;

    marker_codeword_gen u_gen (
        .d        (in_data),
        .mode     (in_mode),
        .codeword (codeword)
    );

    // Handshake: a word transfers on the rising edge where in_valid and in_ready are both
    // high; in_ready is offered in IDLE, and on the last bit of a frame when no gap is
    // configured, so a held in_valid streams frames with no idle cycle between them.
    assign in_ready = ~rst & ((state_q == IDLE) |
                              (BACK_TO_BACK & (state_q == SHIFT) & (bit_cnt_q == '0)));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    shreg_d   = codeword;
                    bit_cnt_d = LAST_BIT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
                    count_d = count_q + 1'b1;
                    if (!BACK_TO_BACK) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else if (accept) begin
                        shreg_d   = codeword;
                        bit_cnt_d = LAST_BIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d   = MSB_FIRST ? {shreg_q[CODE_W-2:0], 1'b0}
                                          : {1'b0, shreg_q[CODE_W-1:1]};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from next state so they leave the block straight from flops.
        ser_valid_d   = (state_d == SHIFT);
        ser_out_d     = ser_valid_d & (MSB_FIRST ? shreg_d[CODE_W-1] : shreg_d[0]);
        frame_start_d = ser_valid_d & (bit_cnt_d == LAST_BIT);
        frame_done_d  = ser_valid_d & (bit_cnt_d == '0);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            count_q       <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            count_q       <= count_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Bench for parity_frame_serializer: three instances (MSB-first, LSB-first, 2-cycle gap)
// checked against a codeword model built from the marker rules.
module tb_parity_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] vld;
    logic [6:0] in_data;
    logic       in_mode;
    logic [2:0] rdy, so, sv, fs, fd, bz;
    logic [7:0] fc [3];

    int checks = 0;
    int errors = 0;
    int exp_cnt [3];

    parity_frame_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0), .CNT_W(8)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(in_data),
        .in_mode(in_mode), .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]),
        .frame_done(fd[0]), .busy(bz[0]), .frame_count(fc[0]));

    parity_frame_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0), .CNT_W(8)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(in_data),
        .in_mode(in_mode), .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]),
        .frame_done(fd[1]), .busy(bz[1]), .frame_count(fc[1]));

    parity_frame_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2), .CNT_W(8)) dut_gap (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(in_data),
        .in_mode(in_mode), .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]),
        .frame_done(fd[2]), .busy(bz[2]), .frame_count(fc[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_codeword(input logic [6:0] d, input logic mode);
        int n1;
        int m;
        int dv;
        dv = int'(d);
        n1 = $countones(d[5:0]);
        if (n1 == 3) m = 0;
        else if (mode) m = (n1 >= 4) ? 1 : 0;
        else m = (n1 <= 2) ? 1 : 0;
        return 8'((dv / 16) * 32 + m * 16 + dv % 16);
    endfunction

    task automatic check_idle_outputs(input int k, input string tag);
        check({tag, "_ready"}, rdy[k], 0);
        check({tag, "_ser_out"}, so[k], 0);
        check({tag, "_ser_valid"}, sv[k], 0);
        check({tag, "_start"}, fs[k], 0);
        check({tag, "_done"}, fd[k], 0);
        check({tag, "_busy"}, bz[k], 0);
        check({tag, "_count"}, fc[k], 0);
    endtask

    task automatic run_frame(input int k, input logic [6:0] d, input logic mode,
                             input logic [7:0] cw);
        int gap;
        gap = (k == 2) ? 2 : 0;
        @(negedge clk);
        check("ready_idle", rdy[k], 1);
        in_data = d;
        in_mode = mode;
        vld[k]  = 1'b1;
        @(negedge clk);
        vld[k]  = 1'b0;
        in_data = 7'($urandom);
        in_mode = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            check("ser_valid", sv[k], 1);
            check("ser_out", so[k], (k == 1) ? cw[i] : cw[7-i]);
            check("frame_start", fs[k], (i == 0));
            check("frame_done", fd[k], (i == 7));
            check("busy", bz[k], 1);
            if (i < 7) check("ready_shift", rdy[k], 0);
            else check("ready_last", rdy[k], (k != 2));
            @(negedge clk);
        end
        exp_cnt[k]++;
        for (int j = 0; j < gap; j++) begin
            check("gap_ready", rdy[k], 0);
            check("gap_valid", sv[k], 0);
            check("gap_busy", bz[k], 1);
            @(negedge clk);
        end
        check("after_valid", sv[k], 0);
        check("after_out", so[k], 0);
        check("after_busy", bz[k], 0);
        check("after_ready", rdy[k], 1);
        check("frame_count", fc[k], exp_cnt[k] % 256);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] d;
        logic       m;
        int         k;
        logic [7:0] cw_a, cw_b;

        rst = 1'b1;
        vld = '0;
        in_data = '0;
        in_mode = 1'b0;
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset");
        rst = 1'b0;

        // Directed codewords, MSB first
        run_frame(0, 7'h00, 1'b0, 8'h10);
        run_frame(0, 7'h7F, 1'b1, 8'hFF);
        run_frame(0, 7'h7F, 1'b0, 8'hEF);
        run_frame(0, 7'h07, 1'b0, 8'h07);
        run_frame(0, 7'h07, 1'b1, 8'h07);
        run_frame(0, 7'h40, 1'b0, 8'h90);

        // LSB first reverses bit order
        run_frame(1, 7'h00, 1'b0, 8'h10);
        run_frame(1, 7'h7F, 1'b0, 8'hEF);

        // Randomised words on both orderings
        for (int r = 0; r < 24; r++) begin
            d = 7'($urandom);
            m = 1'($urandom);
            k = $urandom_range(0, 1);
            run_frame(k, d, m, ref_codeword(d, m));
        end

        // Back-to-back with in_valid held high
        cw_a = 8'h00;
        cw_b = 8'hFF;
        @(negedge clk);
        check("b2b_ready_idle", rdy[0], 1);
        in_data = 7'h00;
        in_mode = 1'b1;
        vld[0]  = 1'b1;
        @(negedge clk);
        in_data = 7'h7F;
        in_mode = 1'b1;
        for (int j = 0; j < 16; j++) begin
            if (j == 8) begin
                vld[0]  = 1'b0;
                in_data = 7'($urandom);
                in_mode = 1'b0;
            end
            check("b2b_valid", sv[0], 1);
            check("b2b_out", so[0], (j < 8) ? cw_a[7-j] : cw_b[15-j]);
            check("b2b_ready", rdy[0], (j % 8 == 7));
            check("b2b_start", fs[0], (j % 8 == 0));
            check("b2b_done", fd[0], (j % 8 == 7));
            @(negedge clk);
        end
        exp_cnt[0] += 2;
        check("b2b_after_valid", sv[0], 0);
        check("b2b_count", fc[0], exp_cnt[0] % 256);

        // Reset during bit 3 of a frame
        @(negedge clk);
        in_data = 7'h2A;
        in_mode = 1'b0;
        vld[0]  = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", sv[0], 1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_idle_outputs(i, "midrst");
        @(negedge clk);
        check("midrst_no_done", fd[0], 0);
        rst = 1'b0;
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        run_frame(0, 7'h2A, 1'b0, ref_codeword(7'h2A, 1'b0));

        // Gap of two cycles, and counter wrap after 256 frames
        for (int r = 0; r < 256; r++) begin
            d = 7'($urandom);
            m = 1'($urandom);
            run_frame(2, d, m, ref_codeword(d, m));
        end
        check("wrap_count", fc[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
